// File: rtl/imem_loader_pkg.sv
// Shared FSM states and frame-format constants for the instruction-memory loader.
// The CHK state only exists when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;
  localparam int HDR_LEN        = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int WCNT_W         = 17;

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
    CHK,
`endif
    FIN
  } state_e;
endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs four payload bytes little-endian into a word; word_valid_o pulses the
// cycle after the fourth byte and word_o holds that word for the pulse.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic        last_o,
  output logic        word_valid_o,
  output logic [31:0] word_o
);
  logic [1:0]  cnt_q;
  logic [31:0] sr_q;
  logic        wv_q;

  assign last_o       = (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word_valid_o = wv_q;
  assign word_o       = sr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      sr_q  <= '0;
      wv_q  <= 1'b0;
    end else begin
      wv_q <= byte_vld_i && last_o;
      if (byte_vld_i) begin
        sr_q  <= {byte_i, sr_q[31:8]};
        cnt_q <= cnt_q + 2'd1;
      end
    end
  end
endmodule

// File: rtl/imem_loader.sv
// Byte-stream boot loader: LEN_LO, LEN_HI, 4*N payload bytes written to imem.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);
  localparam logic [WCNT_W-1:0] DEPTH_C = WCNT_W'(DEPTH);
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e POST_DATA = CHK;
`else
  localparam state_e POST_DATA = FIN;
`endif

  state_e            state_q, state_d;
  logic              rdy_q;
  logic [7:0]        len_lo_q;
  logic [15:0]       len_q;
  logic [WCNT_W-1:0] wacc_q, widx_q;
  logic              err_q, err_d;
  logic              acc, pay_acc, asm_last, word_vld;
  logic [31:0]       word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        xor_q;
`endif

  // rdy_q keeps s_ready low through reset and the edge it is released on
  assign s_ready   = rdy_q && (state_q != FIN);
  assign acc       = s_valid && s_ready;
  assign pay_acc   = acc && (state_q == DATA);
  assign cpu_hold  = (state_q != LEN0);
  assign done      = (state_q == FIN);
  assign err       = err_q;
  assign mem_we    = word_vld && (widx_q < DEPTH_C);
  assign mem_addr  = widx_q[ADDR_W-1:0];
  assign mem_wdata = word;

  word_assembler u_asm (
    .clk          (clk),
    .rst          (rst),
    .byte_vld_i   (pay_acc),
    .byte_i       (s_data),
    .last_o       (asm_last),
    .word_valid_o (word_vld),
    .word_o       (word)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    case (state_q)
      LEN0: if (acc) begin
        state_d = LEN1;
        err_d   = 1'b0;
      end
      LEN1: if (acc) state_d = ({s_data, len_lo_q} == 16'd0) ? POST_DATA : DATA;
      DATA: if (pay_acc && asm_last) begin
        // flag overflow on the completing byte so err is valid in FIN
        if (wacc_q >= DEPTH_C) err_d = 1'b1;
        if (wacc_q + 17'd1 == {1'b0, len_q}) state_d = POST_DATA;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: if (acc) begin
        if (s_data != xor_q) err_d = 1'b1;
        state_d = FIN;
      end
`endif
      FIN:     state_d = LEN0;
      default: state_d = LEN0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= LEN0;
      rdy_q    <= 1'b0;
      len_lo_q <= '0;
      len_q    <= '0;
      wacc_q   <= '0;
      widx_q   <= '0;
      err_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      rdy_q   <= 1'b1;
      if (acc && state_q == LEN0) begin
        len_lo_q <= s_data;
        wacc_q   <= '0;
        widx_q   <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        xor_q    <= '0;
`endif
      end
      if (acc && state_q == LEN1) len_q <= {s_data, len_lo_q};
      if (pay_acc && asm_last)    wacc_q <= wacc_q + 17'd1;
      if (word_vld)               widx_q <= widx_q + 17'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (pay_acc)                xor_q <= xor_q ^ s_data;
`endif
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader; frames are built from word
// lists and the expected writes/err come from the frame rules directly.
module tb_imem_loader;
  localparam int AW = 4;
  localparam int DP = 4;

  logic          clk = 1'b0, rst = 1'b0, s_valid = 1'b0;
  logic [7:0]    s_data = '0;
  logic          s_ready, mem_we, cpu_hold, done, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;

  imem_loader #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // write/done monitor
  typedef struct packed { logic [AW-1:0] a; logic [31:0] d; } wr_t;
  wr_t  got[$];
  int   done_cnt = 0, rises = 0;
  logic err_at_done = 1'b0, prev_hold = 1'b0, prev_done = 1'b0;
  always @(negedge clk) begin
    if (mem_we) got.push_back({mem_addr, mem_wdata});
    if (done) begin done_cnt++; err_at_done = err; end
    if (prev_done) chk("hold_fall", {63'd0, cpu_hold}, 64'd0);
    if (cpu_hold && !prev_hold) rises++;
    prev_hold = cpu_hold;
    prev_done = done;
  end

  // gm: 0 back-to-back, 1 idle cycle before each byte, 2 random idle 0..2
  task automatic send_byte(input logic [7:0] b, input int gm);
    int idle = (gm == 1) ? 1 : (gm == 2) ? int'($urandom_range(0, 2)) : 0;
    bit a = 1'b0;
    int t = 0;
    repeat (idle) @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    while (!a && t < 50) begin
      #1 a = s_ready;
      @(negedge clk);
      t++;
    end
    s_valid = 1'b0;
    if (!a) chk("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic build(input logic [31:0] w[$], input bit bad, output logic [7:0] b[$]);
    int n = w.size();
    logic [7:0] x = '0;
    b.delete();
    b.push_back(n[7:0]);
    b.push_back(n[15:8]);
    foreach (w[i]) for (int k = 0; k < 4; k++) begin
      b.push_back(w[i][8*k +: 8]);
      x ^= w[i][8*k +: 8];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    b.push_back(x ^ {7'd0, bad});
`else
    if (bad) x = '0;
`endif
  endtask

  task automatic send_frame(input logic [31:0] w[$], input int gm, input bit bad);
    logic [7:0] b[$];
    int n = w.size();
    int nw = (n < DP) ? n : DP;
    int d0, t;
    bit exp_err = (n > DP);
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_err = exp_err || bad;
`endif
    build(w, bad, b);
    got.delete();
    rises = 0;
    d0 = done_cnt;
    foreach (b[i]) begin
      send_byte(b[i], gm);
      if (i == 0) begin
        chk("err_clr", {63'd0, err}, 64'd0);
        chk("hold_rise", {63'd0, cpu_hold}, 64'd1);
      end
    end
    t = 0;
    while (done_cnt == d0 && t < 20) begin @(negedge clk); t++; end
    chk("done_seen", {63'd0, done_cnt != d0}, 64'd1);
    repeat (2) @(negedge clk);
    chk("done_cnt", 64'(done_cnt - d0), 64'd1);
    chk("wr_cnt", 64'(got.size()), 64'(nw));
    for (int i = 0; i < nw && i < got.size(); i++) begin
      chk("wr_addr", 64'(got[i].a), 64'(i));
      chk("wr_data", 64'(got[i].d), 64'(w[i]));
    end
    chk("err_done", {63'd0, err_at_done}, {63'd0, exp_err});
    chk("hold_rises", 64'(rises), 64'd1);
  endtask

  initial begin
    logic [31:0] w[$];
    logic [7:0]  b[$];
    #3 chk("rst_outs", 64'({s_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 chk("rdy_pre", {63'd0, s_ready}, 64'd0);
    @(negedge clk);
    chk("rdy_post", {63'd0, s_ready}, 64'd1);

    w = '{32'h0000_0013, 32'h0000_006F};
    send_frame(w, 0, 1'b0);
    send_frame(w, 1, 1'b0);

    w = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444, 32'h5555_5555};
    send_frame(w, 0, 1'b0);
    w.delete();
    send_frame(w, 0, 1'b0);

    // reset after two payload bytes of word 1
    w = '{32'hA1B2_C3D4, 32'hDEAD_BEEF};
    build(w, 1'b0, b);
    got.delete();
    for (int i = 0; i < 8; i++) send_byte(b[i], 0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("rst_mid_outs", 64'({s_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_wr_cnt", 64'(got.size()), 64'd1);
    if (got.size() > 0) chk("rst_wr0", 64'(got[0]), 64'({4'd0, 32'hA1B2_C3D4}));
    w = '{$urandom, $urandom, $urandom};
    send_frame(w, 2, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    w = '{32'h0000_0013, 32'h0000_006F};
    send_frame(w, 0, 1'b1);
`endif

    for (int f = 0; f < 10; f++) begin
      int n = $urandom_range(0, 6);
      w.delete();
      for (int i = 0; i < n; i++) w.push_back($urandom);
      send_frame(w, 2, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
